// File: rtl/asr_pkg.sv
// asr_pkg: shared defaults, FSM state type and width helper for the tap sequencer
//   WIDTH_DATA_DEF / N_TAPS_DEF / N_CH_DEF : default parameter values
//   state_t                                : sequencer states IDLE / SWEEP
//   ch_bits(n)                             : channel index width, at least 1 bit
package asr_pkg;
   localparam int WIDTH_DATA_DEF = 8;
   localparam int N_TAPS_DEF = 16;
   localparam int N_CH_DEF = 2;
   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
   function automatic int ch_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/asr_bank.sv
// asr_bank: one channel's circular delay line with a tap read port and a random-access read port
//   clk, clr      : clock, asynchronous active-low reset
//   i_flush       : synchronous clear of storage and write pointer
//   i_we, i_wdata : write newest sample and advance the pointer
//   i_tap_k       : delay k for o_tap_q = x[n-k]
//   i_add, o_q    : delay for o_q = x[n-add], 0 when add >= N_TAPS
module asr_bank
   import asr_pkg::*;
#(
   parameter int WIDTH_DATA = WIDTH_DATA_DEF,
   parameter int N_TAPS = N_TAPS_DEF
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        i_flush,
   input  logic                        i_we,
   input  logic [WIDTH_DATA-1:0]       i_wdata,
   input  logic [$clog2(N_TAPS)-1:0]   i_tap_k,
   output logic [WIDTH_DATA-1:0]       o_tap_q,
   input  logic [$clog2(N_TAPS):0]     i_add,
   output logic [WIDTH_DATA-1:0]       o_q
);
   localparam int AW = $clog2(N_TAPS);
   localparam logic [AW:0] L_N = (AW+1)'(N_TAPS);
   localparam logic [AW:0] L_NM1 = (AW+1)'(N_TAPS - 1);
   localparam logic [AW-1:0] L_LAST = AW'(N_TAPS - 1);
   logic [WIDTH_DATA-1:0] r_mem [N_TAPS];
   logic [AW-1:0]         r_wp;
   logic [AW-1:0]         w_tap_pos;
   logic [AW-1:0]         w_add_pos;
   // Newest sample sits at wp-1; x[n-k] is at (wp-1-k) mod N_TAPS. Adding N_TAPS-1
   // before subtracting keeps the value non-negative and below 2*N_TAPS, so one
   // conditional subtract is a full modulo even for non-power-of-two depths.
   function automatic logic [AW-1:0] slot(input logic [AW-1:0] wp, input logic [AW-1:0] k);
      logic [AW:0] t;
      t = {1'b0, wp} + L_NM1 - {1'b0, k};
      return (t >= L_N) ? AW'(t - L_N) : t[AW-1:0];
   endfunction
   always_comb begin
      w_tap_pos = slot(r_wp, i_tap_k);
      w_add_pos = slot(r_wp, i_add[AW-1:0]);
      o_tap_q = r_mem[w_tap_pos];
      o_q = (i_add >= L_N) ? '0 : r_mem[w_add_pos];
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_wp <= '0;
         for (int i = 0; i < N_TAPS; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wp <= '0;
         for (int i = 0; i < N_TAPS; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[r_wp] <= i_wdata;
         r_wp <= (r_wp == L_LAST) ? '0 : r_wp + AW'(1);
      end
   end
endmodule

// File: rtl/asr_tap_seq.sv
// asr_tap_seq: multi-channel delay line that sweeps all N_TAPS taps of a channel after each accepted sample
//   clk, clr                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_ch/in_data : sample input handshake
//   flush                       : synchronous clear of all history and the sweep
//   tap_valid/tap_ready/tap_data/tap_idx/tap_ch/tap_last : tap stream x[n-tap_idx]
//   rd_ch, add, q               : combinational random-access read q = x[n-add]
module asr_tap_seq
   import asr_pkg::*;
#(
   parameter int WIDTH_DATA = WIDTH_DATA_DEF,
   parameter int N_TAPS = N_TAPS_DEF,
   parameter int N_CH = N_CH_DEF
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        in_valid,
   input  logic [ch_bits(N_CH)-1:0]    in_ch,
   input  logic [WIDTH_DATA-1:0]       in_data,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        tap_valid,
   input  logic                        tap_ready,
   output logic [WIDTH_DATA-1:0]       tap_data,
   output logic [$clog2(N_TAPS)-1:0]   tap_idx,
   output logic [ch_bits(N_CH)-1:0]    tap_ch,
   output logic                        tap_last,
   input  logic [ch_bits(N_CH)-1:0]    rd_ch,
   input  logic [$clog2(N_TAPS):0]     add,
   output logic [WIDTH_DATA-1:0]       q
);
   localparam int CW = ch_bits(N_CH);
   localparam int IW = $clog2(N_TAPS);
   localparam logic [CW:0] L_NCH = (CW+1)'(N_CH);
   localparam logic [IW-1:0] L_LAST = IW'(N_TAPS - 1);
   state_t                r_state;
   state_t                w_next;
   logic [IW-1:0]         r_idx;
   logic [CW-1:0]         r_ch;
   logic                  r_live;
   logic                  w_accept;
   logic                  w_hs;
   logic [N_CH-1:0]       w_we;
   logic [WIDTH_DATA-1:0] w_tap_q [N_CH];
   logic [WIDTH_DATA-1:0] w_rd_q [N_CH];
   for (genvar g = 0; g < N_CH; g++) begin : g_bank
      assign w_we[g] = w_accept & (in_ch == CW'(g));
      asr_bank #(.WIDTH_DATA(WIDTH_DATA), .N_TAPS(N_TAPS)) u_bank (
         .clk     (clk),
         .clr     (clr),
         .i_flush (flush),
         .i_we    (w_we[g]),
         .i_wdata (in_data),
         .i_tap_k (r_idx),
         .o_tap_q (w_tap_q[g]),
         .i_add   (add),
         .o_q     (w_rd_q[g])
      );
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (flush) w_next = IDLE;
      else if (r_state == IDLE) w_next = w_accept ? SWEEP : IDLE;
      else w_next = (w_hs && tap_last) ? IDLE : SWEEP;
   end
   // r_live stays low through reset and rises on the first edge after it, so
   // in_ready cannot be seen high while clr is asserted.
   always_comb begin
      in_ready = r_live & (r_state == IDLE) & ~flush;
      tap_valid = (r_state == SWEEP);
      tap_last = tap_valid & (r_idx == L_LAST);
      w_accept = in_valid & in_ready;
      w_hs = tap_valid & tap_ready;
      tap_idx = r_idx;
      tap_ch = r_ch;
      tap_data = ({1'b0, r_ch} < L_NCH) ? w_tap_q[r_ch] : '0;
      q = ({1'b0, rd_ch} < L_NCH) ? w_rd_q[rd_ch] : '0;
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_live <= 1'b0;
         r_idx <= '0;
         r_ch <= '0;
      end else begin
         r_live <= 1'b1;
         if (flush || w_accept) r_idx <= '0;
         else if (w_hs) r_idx <= tap_last ? '0 : r_idx + IW'(1);
         if (w_accept) r_ch <= in_ch;
      end
   end
endmodule

// File: doc/asr_tap_seq.md
ASR_TAP_SEQ -- requirements
Module: asr_tap_seq

Interface
REQ-001 WIDTH_DATA, default 8: sample width in bits.
REQ-002 N_TAPS, default 16: delay-line depth per channel; any value >= 2, power of two not required.
REQ-003 N_CH, default 2: number of independent channels; any value >= 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  new sample offered.
REQ-007 in_ch  in  max(1,clog2(N_CH))  channel of offered sample.
REQ-008 in_data  in  WIDTH_DATA  offered sample.
REQ-009 in_ready  out  1  sample accepted when in_valid & in_ready at a clock edge.
REQ-010 flush  in  1  synchronous clear of all history.
REQ-011 tap_valid  out  1  tap stream word valid.
REQ-012 tap_ready  in  1  downstream (MAC) accepts tap word.
REQ-013 tap_data  out  WIDTH_DATA  delayed sample x[n-k] of the swept channel.
REQ-014 tap_idx  out  clog2(N_TAPS)  k, the delay of tap_data.
REQ-015 tap_ch  out  max(1,clog2(N_CH))  channel being swept.
REQ-016 tap_last  out  1  high with the k = N_TAPS-1 word.
REQ-017 rd_ch  in  max(1,clog2(N_CH)); add  in  clog2(N_TAPS)+1; q  out  WIDTH_DATA: random-access read port.

Function
REQ-018 Storage: N_CH circular buffers of N_TAPS words, one write pointer per channel, pointer wraps N_TAPS-1 -> 0.
REQ-019 Accept: write in_data at wp[in_ch], advance wp[in_ch] modulo N_TAPS; other channels untouched.
REQ-020 FSM states IDLE, SWEEP; IDLE -> SWEEP on accept; SWEEP -> IDLE on handshake of tap_last word; any state -> IDLE on flush.
REQ-021 in_ready = (state == IDLE) & ~flush, combinational; in_valid outside IDLE ignored, no buffering.
REQ-022 Latency: tap_valid high the cycle after accept, tap_idx 0, tap_data = sample just accepted.
REQ-023 Each tap_valid & tap_ready handshake increments tap_idx by 1; tap_data = x[n-tap_idx] of tap_ch.
REQ-024 tap_ready low: tap_data, tap_idx, tap_ch, tap_last held stable, tap_valid stays high.
REQ-025 tap_valid low in IDLE; tap_last = tap_valid & (tap_idx == N_TAPS-1).
REQ-026 Throughput with tap_ready tied high: one sample per N_TAPS+1 cycles.
REQ-027 Never-written history positions read as 0.
REQ-028 q = x[n-add] of channel rd_ch, combinational; add >= N_TAPS gives q = 0; add = 0 gives newest sample.
REQ-029 flush: all storage and pointers zero, state IDLE, tap_valid low on the next cycle; flush with in_valid same cycle discards the sample.
REQ-030 No arithmetic on data; pointer arithmetic modulo N_TAPS, no overflow into channel index.

Reset
REQ-031 clr low asynchronously forces: state IDLE, all storage 0, all wp 0, tap_valid 0, tap_idx 0, tap_last 0.
REQ-032 During reset in_ready = 0; in_ready = 1 from the first clock after clr deasserts (with flush low).
REQ-033 Reset mid-SWEEP abandons the sweep; no partial tap stream resumes.

Structure
REQ-034 Shared package asr_pkg holds default WIDTH_DATA/N_TAPS/N_CH values and the IDLE/SWEEP state type.
REQ-035 One sub-module asr_bank: a single channel circular buffer (storage, wp, two read ports), instantiated N_CH times.
REQ-036 Target size 120-400 lines RTL; storage in flops (clear on flush required).

Verification (bench params WIDTH_DATA=8, N_TAPS=4, N_CH=2)
REQ-037 Reset, push ch0 0x11, tap_ready=1 -> tap_data 0x11,0x00,0x00,0x00, tap_idx 0..3, tap_last on 4th word, in_ready high next cycle.
REQ-038 Push ch0 0x01..0x06 -> last sweep 0x06,0x05,0x04,0x03; q with rd_ch=0, add=4 -> 0x00.
REQ-039 After REQ-038, push ch1 0xA0 -> sweep 0xA0,0,0,0, tap_ch=1; q rd_ch=0 add=0 -> 0x06.
REQ-040 tap_ready low 3 cycles at tap_idx=1 -> outputs held, in_ready 0, in_valid ch0 0x55 ignored (not in history).
REQ-041 flush at tap_idx=2 -> tap_valid 0 next cycle, q = 0 for every rd_ch/add, next sweep shows only new sample.
REQ-042 clr pulsed low between edges mid-SWEEP -> outputs reset immediately, history all 0 afterwards.
